// File: rtl/pipeline_pkg.sv
// Shared ID/EX pipeline types: the control and data bundles that ID hands to EX.
// The packed pack is exactly ID_EX_W bits wide and is what the ID/EX FIFO stores.
package pipeline_pkg;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
    } type_EX_CTRL;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } type_MEM_CTRL;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } type_WB_CTRL;

    typedef struct packed {
        logic [4:0]  rd;
        logic [18:0] imm;
    } type_EX_DATA;

    // An all-zero pack has every CTRL bit clear, so it behaves as a bubble in EX.
    typedef struct packed {
        type_EX_CTRL  ex_ctrl;
        type_MEM_CTRL mem_ctrl;
        type_WB_CTRL  wb_ctrl;
        type_EX_DATA  ex_data;
    } type_ID_EX_Pack;

    localparam int ID_EX_W    = $bits(type_ID_EX_Pack);
    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/ififo_if.sv
// ID/EX FIFO handshake bundle: ID writes and EX pops through CTRL, the FIFO serves FIFO.
interface IFIFO #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] wData;
    logic             wen;
    logic             pop;
    logic [WIDTH-1:0] rData;
    logic             isFull;
    logic             isEmpty;

    modport FIFO (input wData, wen, pop, output rData, isFull, isEmpty);
    modport CTRL (output wData, wen, pop, input rData, isFull, isEmpty);
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and count,
    // which keeps the array a plain register file without a reset tree.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/id_ex_fifo.sv
// Show-ahead decoupling FIFO between ID (writer) and EX (reader). Occupancy is kept in
// its own counter so full/empty never depend on pointer comparison.
module id_ex_fifo
    import pipeline_pkg::*;
#(
    parameter int WIDTH = ID_EX_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wData,
    input  logic                       wen,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rData,
    output logic                       isFull,
    output logic                       isEmpty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    IFIFO #(.WIDTH(WIDTH)) fifo_bus ();

    assign fifo_bus.wData = wData;
    assign fifo_bus.wen   = wen;
    assign fifo_bus.pop   = pop;
    assign rData          = fifo_bus.rData;
    assign isFull         = fifo_bus.isFull;
    assign isEmpty        = fifo_bus.isEmpty;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             empty, full;
    logic             pop_ok, push_ok, mem_we;
    logic [WIDTH-1:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign pop_ok  = fifo_bus.pop & ~empty;
    assign push_ok = fifo_bus.wen & (~full | pop_ok);
    assign mem_we  = push_ok & ~flush;

    // NOTE: every variable gets a default at the top of the block so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        err_d   = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
            // A pop on empty paired with a push is simply early, not an error.
            err_d = (fifo_bus.wen & full & ~pop_ok)
                  | (fifo_bus.pop & empty & ~fifo_bus.wen);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wptr_q),
        .wdata(fifo_bus.wData),
        .raddr(rptr_q),
        .rdata(head)
    );

    assign fifo_bus.rData   = empty ? '0 : head;
    assign fifo_bus.isFull  = full;
    assign fifo_bus.isEmpty = empty;
    assign count            = count_q;
    assign err              = err_q;

endmodule

// File: tb/tb_id_ex_fifo.sv
// Directed bench for id_ex_fifo: fill/overflow, full-swap, empty-swap, wrap, flush, async reset.
module tb_id_ex_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [WIDTH-1:0] wData;
    logic             wen;
    logic             pop;
    logic [WIDTH-1:0] rData;
    logic             isFull;
    logic             isEmpty;
    logic [CW-1:0]    count;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wData  (wData),
        .wen    (wen),
        .pop    (pop),
        .rData  (rData),
        .isFull (isFull),
        .isEmpty(isEmpty),
        .count  (count),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, return 1 time unit after the edge with inputs idle.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic p, input logic f);
        wen   = w;
        wData = d;
        pop   = p;
        flush = f;
        @(posedge clk);
        #1;
        wen   = 1'b0;
        wData = '0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [WIDTH-1:0] rd,
                                input int cnt, input logic e);
        check({tag, " rData"}, rData, rd);
        check({tag, " count"}, 32'(count), 32'(cnt));
        check({tag, " err"}, 32'(err), 32'(e));
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wData = '0;
        wen   = 1'b0;
        pop   = 1'b0;
        #12;
        check("reset count", 32'(count), 32'd0);
        check("reset isEmpty", 32'(isEmpty), 32'd1);
        check("reset isFull", 32'(isFull), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset rData", rData, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: fill to full, head stays 0x11, overflow drops and pulses err
        step(1'b1, 32'h11, 1'b0, 1'b0);
        expect_state("t1 push1", 32'h11, 1, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        expect_state("t1 push2", 32'h11, 2, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        expect_state("t1 push3", 32'h11, 3, 1'b0);
        step(1'b1, 32'h44, 1'b0, 1'b0);
        expect_state("t1 push4", 32'h11, 4, 1'b0);
        check("t1 isFull", 32'(isFull), 32'd1);
        step(1'b1, 32'h55, 1'b0, 1'b0);
        expect_state("t1 overflow", 32'h11, 4, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        expect_state("t1 idle", 32'h11, 4, 1'b0);

        // 2: swap while full, then drain in order
        step(1'b1, 32'h55, 1'b1, 1'b0);
        expect_state("t2 swap", 32'h22, 4, 1'b0);
        check("t2 isFull", 32'(isFull), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t2 pop1", 32'h33, 3, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t2 pop2", 32'h44, 2, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t2 pop3", 32'h55, 1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t2 pop4", 32'h0, 0, 1'b0);
        check("t2 isEmpty", 32'(isEmpty), 32'd1);

        // 3: push+pop on empty keeps the push; lone pop on empty is an error
        step(1'b1, 32'hAA, 1'b1, 1'b0);
        expect_state("t3 swap empty", 32'hAA, 1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t3 pop", 32'h0, 0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t3 underflow", 32'h0, 0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t3 err clears", 32'(err), 32'd0);

        // 4: ten push/pop pairs across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
            expect_state($sformatf("t4 push%0d", i), 32'hC0 + 32'(i), 1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            expect_state($sformatf("t4 pop%0d", i), 32'h0, 0, 1'b0);
        end

        // 5: flush beats a simultaneous push
        step(1'b1, 32'h01, 1'b0, 1'b0);
        step(1'b1, 32'h02, 1'b0, 1'b0);
        step(1'b1, 32'h03, 1'b0, 1'b0);
        expect_state("t5 loaded", 32'h01, 3, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b1);
        expect_state("t5 flush", 32'h0, 0, 1'b0);
        check("t5 isEmpty", 32'(isEmpty), 32'd1);
        step(1'b1, 32'h5A, 1'b0, 1'b0);
        expect_state("t5 after flush", 32'h5A, 1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        expect_state("t5 drained", 32'h0, 0, 1'b0);

        // 6: asynchronous reset between edges
        step(1'b1, 32'h61, 1'b0, 1'b0);
        step(1'b1, 32'h62, 1'b0, 1'b0);
        expect_state("t6 loaded", 32'h61, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 async isEmpty", 32'(isEmpty), 32'd1);
        check("t6 async count", 32'(count), 32'd0);
        check("t6 async rData", rData, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'h99, 1'b0, 1'b0);
        expect_state("t6 push after reset", 32'h99, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
